// File: rtl/frame_cache_pkg.sv
// Shared processor constants for the register frame path, plus the
// operation decode used by the frame cache control.
package frame_cache_pkg;

  localparam int REG_W     = 16;
  localparam int NUM_FREGS = 15;
  localparam int FRAME_W   = REG_W * NUM_FREGS;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_SWAP,
    OP_BYPASS,
    OP_OVF,
    OP_UNF
  } op_e;

  // A simultaneous push and pop replaces the top frame (or bypasses when empty).
  function automatic op_e decode_op(input logic push, input logic pop,
                                    input logic full, input logic empty);
    if (push && pop) return empty ? OP_BYPASS : OP_SWAP;
    if (push)        return full  ? OP_OVF    : OP_PUSH;
    if (pop)         return empty ? OP_UNF    : OP_POP;
    return OP_IDLE;
  endfunction

endpackage

// File: rtl/frame_cache_mem.sv
// Frame storage: DEPTH x FRAME_W, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module frame_mem #(
  parameter int DEPTH   = 8,
  parameter int FRAME_W = 240,
  parameter int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [FRAME_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [FRAME_W-1:0] o_rdata
);

  logic [FRAME_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Addresses past DEPTH only occur when the stack is empty and the data is unused.
  assign o_rdata = (32'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/frame_cache.sv
// LIFO of saved register frames for call/return, with a registered restore
// path, occupancy tracking and sticky overflow/underflow flags.
module frame_cache #(
  parameter int DEPTH   = frame_cache_pkg::DEPTH_DEF,
  parameter int FRAME_W = frame_cache_pkg::FRAME_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [FRAME_W-1:0]         save_frame,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr_err,
  output logic [FRAME_W-1:0]         restore_frame,
  output logic                       restore_valid,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] high_water,
  output logic                       err_ovf,
  output logic                       err_unf
);
  import frame_cache_pkg::*;

  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LW-1:0]      r_sp, r_hw, w_sp_nxt, w_top;
  logic [FRAME_W-1:0] r_rf, w_rdata;
  logic               r_rv, r_ovf, r_unf;
  logic               w_full, w_empty, w_we;
  logic [AW-1:0]      w_waddr;
  op_e                w_op;

  assign w_full  = (r_sp == LW'(DEPTH));
  assign w_empty = (r_sp == '0);
  assign w_top   = r_sp - LW'(1);
  assign w_op    = decode_op(push, pop, w_full, w_empty);

  always_comb begin
    w_sp_nxt = r_sp;
    w_we     = 1'b0;
    w_waddr  = w_top[AW-1:0];
    case (w_op)
      OP_PUSH: begin
        w_sp_nxt = r_sp + LW'(1);
        w_we     = 1'b1;
        w_waddr  = r_sp[AW-1:0];
      end
      OP_POP:  w_sp_nxt = w_top;
      OP_SWAP: w_we = 1'b1;
      default: ;
    endcase
  end

  // Read of the old top and overwrite of the same slot coexist in a swap cycle.
  frame_mem #(.DEPTH(DEPTH), .FRAME_W(FRAME_W), .AW(AW)) u_mem (
    .clk     (clk),
    .i_we    (w_we & rst_n),
    .i_waddr (w_waddr),
    .i_wdata (save_frame),
    .i_raddr (w_top[AW-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sp  <= '0;
      r_hw  <= '0;
      r_rf  <= '0;
      r_rv  <= 1'b0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_sp  <= w_sp_nxt;
      r_rv  <= (w_op == OP_POP) || (w_op == OP_SWAP) || (w_op == OP_BYPASS);
      if ((w_op == OP_POP) || (w_op == OP_SWAP)) r_rf <= w_rdata;
      else if (w_op == OP_BYPASS)                r_rf <= save_frame;
      if (w_sp_nxt > r_hw) r_hw <= w_sp_nxt;
      r_ovf <= (r_ovf & ~clr_err) | (w_op == OP_OVF);
      r_unf <= (r_unf & ~clr_err) | (w_op == OP_UNF);
    end
  end

  assign restore_frame = r_rf;
  assign restore_valid = r_rv;
  assign level         = r_sp;
  assign full          = w_full;
  assign empty         = w_empty;
  assign high_water    = r_hw;
  assign err_ovf       = r_ovf;
  assign err_unf       = r_unf;

endmodule

// File: tb/tb_frame_cache.sv
// Directed and random bench for frame_cache with a reference stack model
// and a scoreboard of expected restored frames.
module tb_frame_cache;
  localparam int DEPTH = 8;
  localparam int FW    = 240;
  localparam int LW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] save_frame;
  logic          push, pop, clr_err;
  logic [FW-1:0] restore_frame;
  logic          restore_valid;
  logic [LW-1:0] level, high_water;
  logic          full, empty, err_ovf, err_unf;

  int ntests = 0;
  int nfail  = 0;

  logic [FW-1:0] sb[$];
  logic [FW-1:0] mstk[$];
  logic [FW-1:0] m_rf;
  int            m_hw;
  logic          m_ovf, m_unf;

  frame_cache #(.DEPTH(DEPTH), .FRAME_W(FW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .save_frame    (save_frame),
    .push          (push),
    .pop           (pop),
    .clr_err       (clr_err),
    .restore_frame (restore_frame),
    .restore_valid (restore_valid),
    .level         (level),
    .full          (full),
    .empty         (empty),
    .high_water    (high_water),
    .err_ovf       (err_ovf),
    .err_unf       (err_unf)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] fill(input logic [15:0] v);
    return {15{v}};
  endfunction

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic v);
    logic [FW-1:0] e;
    chk("restore_valid", FW'(restore_valid), FW'(v));
    if (restore_valid === 1'b1) begin
      ntests++;
      assert (sb.size() > 0) else begin
        nfail++;
        $error("FAIL sb_unexpected: observed restore_valid=1 expected no pending frame");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_frame", restore_frame, e);
      end
    end
    chk("restore_hold", restore_frame, m_rf);
    chk("level",        FW'(level),      FW'(mstk.size()));
    chk("full",         FW'(full),       FW'(mstk.size() == DEPTH));
    chk("empty",        FW'(empty),      FW'(mstk.size() == 0));
    chk("high_water",   FW'(high_water), FW'(m_hw));
    chk("err_ovf",      FW'(err_ovf),    FW'(m_ovf));
    chk("err_unf",      FW'(err_unf),    FW'(m_unf));
  endtask

  task automatic step(input logic p, input logic q, input logic c, input logic [FW-1:0] sf);
    logic v, eo, eu;
    v = 1'b0; eo = 1'b0; eu = 1'b0;
    push = p; pop = q; clr_err = c; save_frame = sf;
    if (p && q) begin
      v = 1'b1;
      if (mstk.size() == 0) m_rf = sf;
      else begin
        m_rf = mstk[mstk.size()-1];
        mstk[mstk.size()-1] = sf;
      end
    end else if (p) begin
      if (mstk.size() == DEPTH) eo = 1'b1;
      else mstk.push_back(sf);
    end else if (q) begin
      if (mstk.size() == 0) eu = 1'b1;
      else begin
        m_rf = mstk.pop_back();
        v = 1'b1;
      end
    end
    if (v) sb.push_back(m_rf);
    m_ovf = (m_ovf & ~c) | eo;
    m_unf = (m_unf & ~c) | eu;
    if (mstk.size() > m_hw) m_hw = mstk.size();
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    check_all(v);
  endtask

  task automatic do_reset(input logic p, input logic q);
    rst_n = 1'b0; push = p; pop = q; save_frame = fill(16'hDEAD);
    @(posedge clk); #1;
    rst_n = 1'b1; push = 1'b0; pop = 1'b0;
    mstk.delete(); sb.delete();
    m_rf = '0; m_hw = 0; m_ovf = 1'b0; m_unf = 1'b0;
    check_all(1'b0);
  endtask

  initial begin
    logic [255:0] rw;
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; save_frame = '0;
    m_rf = '0; m_hw = 0; m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk); #1;
    do_reset(1'b1, 1'b1);
    chk("rst_frame", restore_frame, '0);

    // Underflow after reset, then clear
    step(0, 1, 0, '0);
    chk("unf_set", FW'(err_unf), FW'(1));
    step(0, 0, 1, '0);
    chk("unf_clr", FW'(err_unf), FW'(0));

    // LIFO order
    for (int k = 1; k <= 3; k++) step(1, 0, 0, fill(16'(k)));
    step(0, 1, 0, '0); chk("lifo_3", restore_frame, fill(16'h3));
    step(0, 1, 0, '0); chk("lifo_2", restore_frame, fill(16'h2));
    step(0, 1, 0, '0); chk("lifo_1", restore_frame, fill(16'h1));
    chk("lifo_level", FW'(level), FW'(0));
    chk("lifo_hw", FW'(high_water), FW'(3));

    // Fill, overflow, full-swap, set-wins clear
    for (int k = 1; k <= 8; k++) step(1, 0, 0, fill(16'(16'h10 + k)));
    chk("full_at_8", FW'(full), FW'(1));
    step(1, 0, 0, fill(16'h19));
    chk("ovf_set", FW'(err_ovf), FW'(1));
    chk("ovf_level", FW'(level), FW'(8));
    step(1, 1, 0, fill(16'h55));
    chk("full_swap", restore_frame, fill(16'h18));
    chk("full_swap_ovf", FW'(err_ovf), FW'(1));
    step(1, 0, 1, fill(16'h66));
    chk("set_wins", FW'(err_ovf), FW'(1));
    step(0, 0, 1, '0);
    chk("ovf_clr", FW'(err_ovf), FW'(0));
    step(0, 1, 0, '0);
    chk("pop_after_swap", restore_frame, fill(16'h55));
    for (int k = 0; k < 7; k++) step(0, 1, 0, '0);
    chk("drain_frame1", restore_frame, fill(16'h11));
    chk("hw_sat", FW'(high_water), FW'(8));

    // Swap with level 2
    step(1, 0, 0, fill(16'h1));
    step(1, 0, 0, fill(16'h2));
    step(1, 1, 0, fill(16'hAA));
    chk("swap_old", restore_frame, fill(16'h2));
    chk("swap_level", FW'(level), FW'(2));
    step(0, 1, 0, '0);
    chk("swap_new", restore_frame, fill(16'hAA));
    step(0, 1, 0, '0);

    // Bypass when empty
    step(1, 1, 0, fill(16'h1234));
    chk("bypass_frame", restore_frame, fill(16'h1234));
    chk("bypass_valid", FW'(restore_valid), FW'(1));
    chk("bypass_level", FW'(level), FW'(0));
    chk("bypass_noerr", FW'({err_ovf, err_unf}), FW'(0));

    // Mid-sequence reset discards frames
    for (int k = 1; k <= 4; k++) step(1, 0, 0, fill(16'(16'h40 + k)));
    do_reset(1'b0, 1'b1);
    chk("mid_rst_level", FW'(level), FW'(0));
    chk("mid_rst_hw", FW'(high_water), FW'(0));
    chk("mid_rst_frame", restore_frame, '0);
    step(0, 1, 0, '0);
    chk("mid_rst_unf", FW'(err_unf), FW'(1));

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < 8; j++) rw[j*32 +: 32] = $urandom();
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), rw[FW-1:0]);
    end

    chk("sb_drained", FW'(sb.size()), FW'(0));
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/frame_cache.md
FRAME_CACHE -- requirements
Module: frame_cache

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of saved register frames.
REQ-002 The block SHALL have parameter FRAME_W, default 240, giving the frame width (15 x 16-bit registers f0-f14).
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port save_frame, input, FRAME_W: frame driven by the register management stage's fcOut.
REQ-006 Port push, input, 1: save save_frame on the top of the stack (call).
REQ-007 Port pop, input, 1: return the top frame (function return).
REQ-008 Port clr_err, input, 1: clear the sticky error flags.
REQ-009 Port restore_frame, output, FRAME_W, registered: frame fed to the register stage's fcIn.
REQ-010 Port restore_valid, output, 1: one-cycle pulse when restore_frame is updated.
REQ-011 Port level, output, $clog2(DEPTH+1): number of stored frames.
REQ-012 Port full and empty, outputs, 1 each: combinational from level (level==DEPTH, level==0).
REQ-013 Port high_water, output, $clog2(DEPTH+1): maximum level seen since reset.
REQ-014 Port err_ovf and err_unf, outputs, 1 each: sticky overflow and underflow flags.

Function
REQ-015 Storage SHALL be a LIFO of DEPTH entries with stack pointer sp equal to level; entry sp-1 is the top.
REQ-016 Push only, not full: mem[sp] <= save_frame, sp+1; restore_frame unchanged; restore_valid=0.
REQ-017 Pop only, not empty: restore_frame <= mem[sp-1], sp-1, restore_valid=1 next cycle (latency 1).
REQ-018 Push when full (push only): push ignored, memory/sp unchanged, err_ovf <= 1.
REQ-019 Pop when empty (pop only): pop ignored, restore_frame held, restore_valid=0, err_unf <= 1.
REQ-020 Push and pop together, not empty: restore_frame <= mem[sp-1] (old value), mem[sp-1] <= save_frame, sp unchanged, restore_valid=1.
REQ-021 Push and pop together, empty: bypass; restore_frame <= save_frame, sp stays 0, restore_valid=1, no error.
REQ-022 Push and pop together when full SHALL follow REQ-020; no overflow.
REQ-023 restore_frame SHALL hold its value in every cycle without a successful pop.
REQ-024 high_water SHALL update to the new level whenever the new level exceeds it; it saturates at DEPTH.
REQ-025 clr_err SHALL clear err_ovf/err_unf; an error event in the same cycle sets the flag (set wins).
REQ-026 sp arithmetic SHALL never wrap: sp is confined to the range 0..DEPTH.

Reset
REQ-027 When rst_n=0 at a clock edge: sp=0, restore_frame=0, restore_valid=0, high_water=0, err_ovf=0, err_unf=0; push/pop in that cycle are ignored.
REQ-028 Memory contents SHALL NOT be reset; nothing may read memory above sp.
REQ-029 A reset asserted mid-sequence SHALL discard all frames; the first pop after reset sets err_unf.

Structure
REQ-030 FRAME_W, REG_W=16, NUM_FREGS=15 and DEPTH default SHALL live in the processor's shared constants package, shared with the register stage.
REQ-031 Frame packing SHALL be {f14..f0} with f0 in bits [15:0], matching fcIn/fcOut.
REQ-032 A single sub-module, frame_mem (DEPTH x FRAME_W, one write port, one read port), is natural; the control logic and pointer stay in frame_cache.

Verification
REQ-033 Reset, then pop -> restore_valid=0, err_unf=1, level=0; then clr_err -> err_unf=0.
REQ-034 Push frames with every field = k for k=1..3, then pop x3 -> restore_frame fields 3, 2, 1 on consecutive cycles; restore_valid=1 each cycle; level ends at 0; high_water=3.
REQ-035 Push 9 frames (DEPTH=8) -> full=1 after the 8th push, err_ovf=1 after the 9th, level=8; then pop -> restore_frame is frame 8.
REQ-036 With level=2 (top frame fields=0x0002), push+pop with save_frame fields=0x00AA -> restore_frame fields=0x0002, level=2; next pop -> 0x00AA.
REQ-037 When empty, push+pop with save_frame=0x1234 in all fields -> restore_frame=0x1234 in all fields, restore_valid=1, level=0, no error flags.
REQ-038 Push 4 frames, assert rst_n=0 for one cycle -> level=0, high_water=0, restore_frame=0; then pop -> err_unf=1.
